// File: rtl/viterbi_stream_decoder.sv
// Streaming hard-decision Viterbi decoder. Trellis tables arrive on ports, all path metrics
// update in parallel per symbol, and decoded words come from a fixed-depth survivor ring.
module viterbi_stream_decoder #(
    parameter int unsigned K    = 1,
    parameter int unsigned M    = 3,
    parameter int unsigned N    = 2,
    parameter int unsigned TB   = 16,
    parameter int unsigned MW   = 8,
    parameter int unsigned TERM = 1,
    localparam int unsigned SW  = M - K,
    localparam int unsigned S   = 2 ** SW,
    localparam int unsigned B   = 2 ** K
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [S*B*SW-1:0]   next_states,
    input  logic [S*B*N-1:0]    out_symbols,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_sym,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [K-1:0]        out_data,
    output logic                out_last,
    output logic [MW-1:0]       out_metric
);

    localparam int unsigned PW  = (TB > 1) ? $clog2(TB) : 1;
    localparam int unsigned FW  = $clog2(TB + 1);
    localparam int unsigned DW  = $clog2(N + 1);
    localparam int unsigned MW1 = MW + 1;
    localparam logic [MW-1:0] PMAX = '1;
    localparam logic [MW-1:0] HALF = {1'b1, {(MW-1){1'b0}}};

    typedef enum logic [2:0] {S_IN, S_TRACE, S_OUT, S_FTRACE, S_FOUT} state_t;

    state_t          state;
    logic [MW-1:0]   pm       [S];
    logic [MW-1:0]   pm_acs   [S];
    logic [MW-1:0]   pm_new   [S];
    logic [SW-1:0]   surv_pred[S];
    logic [K-1:0]    surv_j   [S];
    logic            acs_has  [S];
    logic [SW+K-1:0] ring     [TB][S];
    logic [K-1:0]    fbuf     [TB];

    logic [SW-1:0]   acs_ns;
    logic [MW:0]     acs_sum;
    logic [MW-1:0]   acs_cand;
    logic [MW-1:0]   pm_min;
    logic [MW-1:0]   best_val;
    logic [SW-1:0]   best;
    logic [SW-1:0]   start;

    logic [PW-1:0]   wr_ptr, wr_ptr_inc, tb_ptr, tb_ptr_dec, tb_cnt, out_idx, out_idx_inc, age, fill_top;
    logic [FW-1:0]   fill, fill_inc;
    logic [SW-1:0]   tb_state, tr_pred;
    logic [K-1:0]    cur_j, prev_j;
    logic            accept;

    function automatic logic [DW-1:0] popc(input logic [N-1:0] v);
        logic [DW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + DW'(v[i]);
        return c;
    endfunction

    // Add-compare-select: first strictly-better candidate wins, giving lowest s then lowest j on ties
    always_comb begin
        acs_ns   = '0;
        acs_sum  = '0;
        acs_cand = '0;
        for (int d = 0; d < S; d++) begin
            pm_acs[d]    = PMAX;
            surv_pred[d] = '0;
            surv_j[d]    = '0;
            acs_has[d]   = 1'b0;
        end
        for (int s = 0; s < S; s++) begin
            for (int j = 0; j < B; j++) begin
                acs_ns   = next_states[(s*B+j)*SW +: SW];
                acs_sum  = {1'b0, pm[s]} + MW1'(popc(in_sym ^ out_symbols[(s*B+j)*N +: N]));
                acs_cand = (acs_sum > {1'b0, PMAX}) ? PMAX : acs_sum[MW-1:0];
                if (pm[s] != PMAX && (!acs_has[acs_ns] || acs_cand < pm_acs[acs_ns])) begin
                    acs_has[acs_ns]   = 1'b1;
                    pm_acs[acs_ns]    = acs_cand;
                    surv_pred[acs_ns] = SW'(s);
                    surv_j[acs_ns]    = K'(j);
                end
            end
        end
    end

    // Normalisation keeps reachable metrics in the lower half; unreachable states stay pinned at PMAX
    always_comb begin
        pm_min = PMAX;
        for (int d = 0; d < S; d++)
            if (pm_acs[d] < pm_min) pm_min = pm_acs[d];
        for (int d = 0; d < S; d++)
            pm_new[d] = (pm_min >= HALF && pm_acs[d] != PMAX) ? pm_acs[d] - HALF : pm_acs[d];
        best     = '0;
        best_val = pm_new[0];
        for (int d = 1; d < S; d++) begin
            if (pm_new[d] < best_val) begin
                best     = SW'(d);
                best_val = pm_new[d];
            end
        end
    end

    assign start       = (TERM != 0) ? '0 : best;
    assign accept      = in_valid && in_ready;
    assign wr_ptr_inc  = (wr_ptr == PW'(TB - 1)) ? '0 : wr_ptr + PW'(1);
    assign tb_ptr_dec  = (tb_ptr == '0) ? PW'(TB - 1) : tb_ptr - PW'(1);
    assign fill_inc    = fill + FW'(1);
    assign fill_top    = PW'(fill - FW'(1));
    assign age         = fill_top - tb_cnt;
    assign out_idx_inc = out_idx + PW'(1);
    assign tr_pred     = ring[tb_ptr][tb_state][SW+K-1:K];
    assign cur_j       = ring[tb_ptr][tb_state][K-1:0];
    assign prev_j      = ring[tb_ptr_dec][tr_pred][K-1:0];

    // Survivor ring and flush buffer carry no reset; fill and pointers define what is valid
    always_ff @(posedge clk) begin
        if (!reset && state == S_IN && accept)
            for (int d = 0; d < S; d++) ring[wr_ptr][d] <= {surv_pred[d], surv_j[d]};
        if (!reset && state == S_FTRACE)
            fbuf[age] <= cur_j;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IN;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_metric <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            tb_ptr     <= '0;
            tb_cnt     <= '0;
            tb_state   <= '0;
            out_idx    <= '0;
            for (int i = 0; i < S; i++) pm[i] <= (i == 0) ? MW'(0) : PMAX;
        end else begin
            case (state)
                S_IN: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        for (int i = 0; i < S; i++) pm[i] <= pm_new[i];
                        wr_ptr <= wr_ptr_inc;
                        fill   <= fill_inc;
                        tb_ptr <= wr_ptr;
                        tb_cnt <= '0;
                        if (in_last) begin
                            state      <= S_FTRACE;
                            in_ready   <= 1'b0;
                            tb_state   <= start;
                            out_metric <= pm_new[start];
                        end else if (fill_inc == FW'(TB)) begin
                            state    <= S_TRACE;
                            in_ready <= 1'b0;
                            tb_state <= best;
                        end
                    end
                end
                // Last walk step also reads the oldest entry's input word
                S_TRACE: begin
                    if (tb_cnt == PW'(TB - 2)) begin
                        out_data  <= prev_j;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        state     <= S_OUT;
                    end else begin
                        tb_state <= tr_pred;
                        tb_ptr   <= tb_ptr_dec;
                        tb_cnt   <= tb_cnt + PW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fill      <= fill - FW'(1);
                        in_ready  <= 1'b1;
                        state     <= S_IN;
                    end
                end
                S_FTRACE: begin
                    if (tb_cnt == fill_top) begin
                        out_data  <= cur_j;
                        out_valid <= 1'b1;
                        out_last  <= (fill == FW'(1));
                        out_idx   <= '0;
                        state     <= S_FOUT;
                    end else begin
                        tb_state <= tr_pred;
                        tb_ptr   <= tb_ptr_dec;
                        tb_cnt   <= tb_cnt + PW'(1);
                    end
                end
                // Flush drains oldest-first, then the decoder re-arms as if freshly reset
                S_FOUT: begin
                    if (out_ready) begin
                        if (out_idx == fill_top) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            wr_ptr    <= '0;
                            fill      <= '0;
                            in_ready  <= 1'b1;
                            state     <= S_IN;
                            for (int i = 0; i < S; i++) pm[i] <= (i == 0) ? MW'(0) : PMAX;
                        end else begin
                            out_idx  <= out_idx_inc;
                            out_data <= fbuf[out_idx_inc];
                            out_last <= (out_idx_inc == fill_top);
                        end
                    end
                end
                default: state <= S_IN;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// Directed bench for viterbi_stream_decoder: rate-1/2 (7,5) code, one TB16/MW8 and one TB4/MW4 instance.
module tb_viterbi_stream_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] ns_tab;
    logic [15:0] os_tab;
    logic        in_valid_a, in_valid_b, in_ready_a, in_ready_b;
    logic [1:0]  in_sym;
    logic        in_last;
    logic        out_ready;
    logic        ov_a, ov_b, ol_a, ol_b;
    logic [0:0]  od_a, od_b;
    logic [7:0]  om_a;
    logic [3:0]  om_b;

    logic        sel;
    logic        ov, ol, ir;
    logic [0:0]  od;
    logic [7:0]  om;

    logic        q_data[$];
    logic        q_last[$];
    logic [1:0]  frame[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    viterbi_stream_decoder #(.K(1), .M(3), .N(2), .TB(16), .MW(8), .TERM(1)) dut_a (
        .clk(clk), .reset(reset), .next_states(ns_tab), .out_symbols(os_tab),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_sym(in_sym), .in_last(in_last),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_last(ol_a), .out_metric(om_a));

    viterbi_stream_decoder #(.K(1), .M(3), .N(2), .TB(4), .MW(4), .TERM(1)) dut_b (
        .clk(clk), .reset(reset), .next_states(ns_tab), .out_symbols(os_tab),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sym(in_sym), .in_last(in_last),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_last(ol_b), .out_metric(om_b));

    assign ov = sel ? ov_b : ov_a;
    assign ol = sel ? ol_b : ol_a;
    assign ir = sel ? in_ready_b : in_ready_a;
    assign od = sel ? od_b : od_a;
    assign om = sel ? 8'(om_b) : om_a;

    always @(negedge clk) begin
        if (ov && out_ready) begin
            q_data.push_back(od[0]);
            q_last.push_back(ol);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] sym, input logic last);
        int n;
        n = 0;
        in_sym  = sym;
        in_last = last;
        if (sel) in_valid_b = 1'b1;
        else     in_valid_a = 1'b1;
        while (!ir && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("in_ready_timeout", 32'(ir), 32'd1);
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic send_range(input int first, input int last_idx);
        for (int i = first; i <= last_idx; i++)
            send_sym(frame[i], (i == frame.size() - 1));
    endtask

    task automatic wait_words(input int n);
        int c;
        c = 0;
        while (q_data.size() < n && c < 600) begin
            tick();
            c++;
        end
        repeat (4) tick();
    endtask

    function automatic logic [31:0] data_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < q_data.size() && i < 32; i++) v[i] = q_data[i];
        return v;
    endfunction

    function automatic int n_lasts();
        int c;
        c = 0;
        foreach (q_last[i]) if (q_last[i]) c++;
        return c;
    endfunction

    function automatic int first_last();
        foreach (q_last[i]) if (q_last[i]) return i;
        return -1;
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
    endtask

    initial begin
        logic [1:0] st;
        logic       jb;
        logic       stable;

        // (7,5) code: state = {u[t-1], u[t-2]}, symbol = {g0=111, g1=101}
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 2; j++) begin
                st = 2'(s);
                jb = 1'(j);
                ns_tab[(s*2+j)*2 +: 2] = {jb, st[1]};
                os_tab[(s*2+j)*2 +: 2] = {jb ^ st[1] ^ st[0], jb ^ st[0]};
            end
        end
        reset = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0; in_sym = 2'd0;
        in_last = 1'b0; out_ready = 1'b1; sel = 1'b0;

        tick(); tick();
        check("rst_out_valid", 32'(ov), 32'd0);
        check("rst_in_ready", 32'(ir), 32'd0);
        check("rst_out_data", 32'(od), 32'd0);
        check("rst_out_last", 32'(ol), 32'd0);
        check("rst_out_metric", 32'(om), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_release_ready", 32'(ir), 32'd1);

        // T1: clean frame, decode 0,1,1,0,1,0,0
        frame = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3};
        clear_q();
        send_range(0, 6);
        wait_words(7);
        check("t1_words", 32'(q_data.size()), 32'd7);
        check("t1_data", data_vec(), 32'h16);
        check("t1_last_cnt", 32'(n_lasts()), 32'd1);
        check("t1_last_pos", 32'(first_last()), 32'd6);
        check("t1_metric", 32'(om), 32'd0);

        // T2: third symbol corrupted 01 -> 11
        frame = '{2'd0, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
        clear_q();
        send_range(0, 6);
        wait_words(7);
        check("t2_words", 32'(q_data.size()), 32'd7);
        check("t2_data", data_vec(), 32'h16);
        check("t2_metric", 32'(om), 32'd1);

        // T3: TB4 zero frame of 20 with traceback latency
        sel = 1'b1;
        frame.delete();
        for (int i = 0; i < 20; i++) frame.push_back(2'd0);
        clear_q();
        send_range(0, 3);
        check("t3_ready_e0", 32'(ir), 32'd0);
        check("t3_valid_e0", 32'(ov), 32'd0);
        tick();
        check("t3_valid_e1", 32'(ov), 32'd0);
        tick();
        check("t3_valid_e2", 32'(ov), 32'd0);
        check("t3_ready_e2", 32'(ir), 32'd0);
        tick();
        check("t3_valid_e3", 32'(ov), 32'd1);
        check("t3_ready_e3", 32'(ir), 32'd0);
        send_range(4, 19);
        wait_words(20);
        check("t3_words", 32'(q_data.size()), 32'd20);
        check("t3_data", data_vec(), 32'h0);
        check("t3_last_cnt", 32'(n_lasts()), 32'd1);
        check("t3_last_pos", 32'(first_last()), 32'd19);

        // T5: 40 symbols all 11 with 4-bit metrics
        frame.delete();
        for (int i = 0; i < 40; i++) frame.push_back(2'd3);
        clear_q();
        send_range(0, 39);
        wait_words(40);
        check("t5_words", 32'(q_data.size()), 32'd40);
        check("t5_last_cnt", 32'(n_lasts()), 32'd1);
        check("t5_last_pos", 32'(first_last()), 32'd39);
        check("t5_metric_bound", 32'(om <= 8'd11), 32'd1);

        // T4: back-pressure in S_OUT on TB4, then finish T1 frame
        frame = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3};
        clear_q();
        out_ready = 1'b0;
        send_range(0, 3);
        tick(); tick(); tick();
        check("t4_valid", 32'(ov), 32'd1);
        check("t4_first_word", 32'(od), 32'd0);
        in_sym = frame[4];
        in_valid_b = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(ov === 1'b1 && od === 1'b0 && ir === 1'b0)) stable = 1'b0;
        end
        check("t4_hold_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        send_range(4, 6);
        wait_words(7);
        check("t4_words", 32'(q_data.size()), 32'd7);
        check("t4_data", data_vec(), 32'h16);
        check("t4_last_pos", 32'(first_last()), 32'd6);
        check("t4_metric", 32'(om), 32'd0);

        // T6: reset during flush output, then clean re-decode
        sel = 1'b0;
        frame = '{2'd0, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
        clear_q();
        out_ready = 1'b0;
        send_range(0, 6);
        for (int i = 0; i < 40 && !ov; i++) tick();
        check("t6_fout_valid", 32'(ov), 32'd1);
        check("t6_fout_metric", 32'(om), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", 32'(ov), 32'd0);
        check("t6_rst_metric", 32'(om), 32'd0);
        check("t6_rst_ready", 32'(ir), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        clear_q();
        tick();
        frame = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3};
        send_range(0, 6);
        wait_words(7);
        check("t6_words", 32'(q_data.size()), 32'd7);
        check("t6_data", data_vec(), 32'h16);
        check("t6_last_pos", 32'(first_last()), 32'd6);
        check("t6_metric", 32'(om), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
